// File: rtl/mmio_pkg.sv
// Shared types and constants for the EX_DM memory-mapped I/O bridge.
// Region 0 is the internal data memory; regions 1..NUM_CH map to external channels.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int          REGION_INT   = 0;
    localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

    // Region r (1..NUM_CH) selects external channel r-1.
    function automatic int region_to_ch(input int region);
        return region - 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decode: internal DM, one of NUM_CH channels, or unmapped.
// Kept separate so the I/O address map can reuse it.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int REGION_W = 3,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2
) (
    input  logic [REGION_W-1:0] region,
    output logic                is_int,
    output logic                is_unmapped,
    output logic [CH_W-1:0]     ch_idx
);

    int w_region_i;

    always_comb begin
        w_region_i  = int'(region);
        is_int      = (w_region_i == REGION_INT);
        is_unmapped = (w_region_i > NUM_CH);
        ch_idx      = '0;
        if (!is_int && !is_unmapped) begin
            ch_idx = CH_W'(region_to_ch(w_region_i));
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// EX_DM memory bridge: internal DM accesses pass straight through, external channel
// accesses run a req/ack handshake with wait states and timeout while stalling the pipeline.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                REGION_W = 3,
    parameter int                NUM_CH   = 4,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic [DATA_W-1:0]        dm_rdata,
    output logic                     dm_we,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     stall,
    output logic                     bus_err,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_we,
    output logic [ADDR_W-1:0]        ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]        ch_ack
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic                w_is_int;
    logic                w_is_unmapped;
    logic [CH_W-1:0]     w_idx;
    logic                w_access;
    logic                w_ext;
    logic                w_ack;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_slice;

    logic [CH_W-1:0]     r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_CH-1:0]   r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    mmio_decode #(
        .REGION_W (REGION_W),
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W)
    ) u_decode (
        .region      (cpu_addr[ADDR_W-1 -: REGION_W]),
        .is_int      (w_is_int),
        .is_unmapped (w_is_unmapped),
        .ch_idx      (w_idx)
    );

    assign w_access  = cpu_re | cpu_we;
    assign w_ext     = w_access & ~w_is_int & ~w_is_unmapped;
    assign w_ack     = ch_ack[r_idx];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_slice   = ch_rdata[int'(r_idx)*DATA_W +: DATA_W];

    assign ch_req   = r_req;
    assign ch_we    = r_we;
    assign ch_addr  = r_addr;
    assign ch_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE always returns to IDLE so the access still presented while the pipeline advances never restarts.
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        bus_err   = 1'b0;
        cpu_rdata = dm_rdata;
        dm_we     = cpu_we & w_is_int;
        case (r_state)
            IDLE: begin
                if (w_access && w_is_unmapped) begin
                    bus_err   = 1'b1;
                    cpu_rdata = ERR_DATA;
                end
                if (w_ext) begin
                    stall  = 1'b1;
                    w_next = WAIT;
                end
            end
            WAIT: begin
                stall     = 1'b1;
                cpu_rdata = r_rdata;
                if (w_ack || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                cpu_rdata = r_rdata;
                bus_err   = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Ack takes priority over timeout when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_ext) begin
                        r_idx   <= w_idx;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_we    <= cpu_we;
                        r_req   <= NUM_CH'(1) << w_idx;
                        r_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_ack) begin
                        r_rdata <= w_slice;
                        r_err   <= 1'b0;
                        r_req   <= '0;
                        r_we    <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_req   <= '0;
                        r_we    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge: internal, channel, timeout,
// unmapped and reset-during-WAIT accesses against hand-computed expectations.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] dm_rdata;
    logic        dm_we;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic        bus_err;
    logic [3:0]  ch_req;
    logic        ch_we;
    logic [15:0] ch_addr;
    logic [15:0] ch_wdata;
    logic [63:0] ch_rdata;
    logic [3:0]  ch_ack;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    mmio_bridge #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .REGION_W (3),
        .NUM_CH   (4),
        .TIMEOUT  (15),
        .ERR_DATA (16'hDEAD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .dm_rdata  (dm_rdata),
        .dm_we     (dm_we),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_ack    (ch_ack)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic re, input logic we, input logic [15:0] wdata);
        cpu_addr  = addr;
        cpu_re    = re;
        cpu_we    = we;
        cpu_wdata = wdata;
    endtask

    // One external access; ackAfter is the WAIT-cycle index of the ack, -1 for never.
    task automatic doAccess(input string name, input logic [15:0] addr, input logic re, input logic we,
                            input logic [15:0] wdata, input int ackAfter, input int expStall,
                            input int expReq, input logic [15:0] expData, input logic expErr);
        int         stallCycles = 0;
        int         reqCycles   = 0;
        logic       finished    = 1'b0;
        logic [3:0] expOneHot;
        expOneHot = 4'b0001 << (int'(addr[15:13]) - 1);
        @(posedge clk); #1;
        applyStimulus(addr, re, we, wdata);
        for (int cyc = 0; cyc < 40; cyc++) begin
            ch_ack = (ackAfter >= 0 && cyc == ackAfter + 1) ? expOneHot : 4'b0000;
            #1;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
            stallCycles++;
            if (ch_req != 4'b0000) begin
                reqCycles++;
                checkOutput({name, ".req"}, ch_req, expOneHot);
                checkOutput({name, ".addr"}, ch_addr, addr);
                checkOutput({name, ".wdata"}, ch_wdata, wdata);
                checkOutput({name, ".we"}, ch_we, we);
            end
            @(posedge clk); #1;
        end
        checkOutput({name, ".finished"}, finished, 1'b1);
        checkOutput({name, ".stallCycles"}, stallCycles, expStall);
        checkOutput({name, ".reqCycles"}, reqCycles, expReq);
        checkOutput({name, ".rdata"}, cpu_rdata, expData);
        checkOutput({name, ".busErr"}, bus_err, expErr);
        @(posedge clk); #1;
        ch_ack = 4'b0000;
        applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput({name, ".noRestartReq"}, ch_req, 4'b0000);
        checkOutput({name, ".noRestartStall"}, stall, 1'b0);
        checkOutput({name, ".errPulseEnd"}, bus_err, 1'b0);
        checkOutput({name, ".addrHold"}, ch_addr, addr);
        checkOutput({name, ".wdataHold"}, ch_wdata, wdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        ch_ack   = 4'b0000;
        dm_rdata = 16'h0000;
        ch_rdata = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
        applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
        #2;
        checkOutput("reset.stall", stall, 1'b0);
        checkOutput("reset.req", ch_req, 4'b0000);
        checkOutput("reset.we", ch_we, 1'b0);
        checkOutput("reset.addr", ch_addr, 16'h0000);
        checkOutput("reset.busErr", bus_err, 1'b0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        @(posedge clk); #1;
        dm_rdata = 16'h1234;
        applyStimulus(16'h0040, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("intLoad.rdata", cpu_rdata, 16'h1234);
        checkOutput("intLoad.stall", stall, 1'b0);
        checkOutput("intLoad.req", ch_req, 4'b0000);
        checkOutput("intLoad.dmWe", dm_we, 1'b0);
        applyStimulus(16'h0040, 1'b0, 1'b1, 16'h5A5A);
        #1;
        checkOutput("intStore.dmWe", dm_we, 1'b1);
        checkOutput("intStore.stall", stall, 1'b0);
        @(posedge clk); #1;
        checkOutput("intStore.noReq", ch_req, 4'b0000);
        applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);

        doAccess("ch0Read", 16'h2010, 1'b1, 1'b0, 16'h0000, 0, 2, 1, 16'hBEEF, 1'b0);
        doAccess("ch2Write", 16'h6004, 1'b0, 1'b1, 16'hA5A5, 5, 7, 6, 16'h2222, 1'b0);
        doAccess("ch1Timeout", 16'h4000, 1'b1, 1'b0, 16'h0000, -1, 16, 15, 16'hDEAD, 1'b1);

        @(posedge clk); #1;
        applyStimulus(16'hA000, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("unmapped.busErr", bus_err, 1'b1);
        checkOutput("unmapped.rdata", cpu_rdata, 16'hDEAD);
        checkOutput("unmapped.stall", stall, 1'b0);
        @(posedge clk); #1;
        applyStimulus(16'hE000, 1'b0, 1'b1, 16'h1111);
        #1;
        checkOutput("unmapped.noReq", ch_req, 4'b0000);
        checkOutput("unmappedW.dmWe", dm_we, 1'b0);
        checkOutput("unmappedW.busErr", bus_err, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);

        @(posedge clk); #1;
        applyStimulus(16'h8000, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("rstMid.idleStall", stall, 1'b1);
        @(posedge clk); #1;
        ch_ack = 4'b0001;
        #1;
        checkOutput("rstMid.req", ch_req, 4'b1000);
        @(posedge clk); #1;
        ch_ack = 4'b0000;
        #1;
        checkOutput("rstMid.strayStall", stall, 1'b1);
        checkOutput("rstMid.strayReq", ch_req, 4'b1000);
        rst_n = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("rstMid.reqCleared", ch_req, 4'b0000);
        checkOutput("rstMid.stallCleared", stall, 1'b0);
        checkOutput("rstMid.addrCleared", ch_addr, 16'h0000);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ch_rdata[15:0] = 16'h1357;
        doAccess("postRst", 16'h2002, 1'b1, 1'b0, 16'h0000, 2, 4, 3, 16'h1357, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised successor to the single-cycle internal/external memory split at the CPU EX_DM stage.
- Decodes the data address into the internal DM or one of NUM_CH external peripheral channels.
- Runs a req/ack handshake with wait states and a timeout on external channels, stalling the pipeline until the access completes.
- Returns read data to the dst mux and flags unmapped or timed-out accesses.

Parameters:
- DATA_W, 16, data bus width
- ADDR_W, 16, address width
- REGION_W, 3, top address bits used for region decode; region 0 is internal DM
- NUM_CH, 4, external channels, mapped to regions 1..NUM_CH; must be ≤ 2^REGION_W-1
- TIMEOUT, 15, max WAIT cycles before the access is aborted; 0 disables the timeout
- ERR_DATA, 16'hDEAD, read data returned on error

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_W  address from EX_DM (ALU result)
- cpu_re  in  1  load in EX_DM
- cpu_we  in  1  store in EX_DM
- cpu_wdata  in  DATA_W  store data (p0_EX_DM)
- dm_rdata  in  DATA_W  internal DM read data
- dm_we  out  1  qualified internal DM write enable
- cpu_rdata  out  DATA_W  read data to dst mux
- stall  out  1  freezes IM_ID/ID_EX/EX_DM
- bus_err  out  1  one-cycle error pulse
- ch_req  out  NUM_CH  one-hot request, held until ack/timeout
- ch_we  out  1  write qualifier for the active request
- ch_addr  out  ADDR_W  latched address
- ch_wdata  out  DATA_W  latched write data
- ch_rdata  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- ch_ack  in  NUM_CH  per-channel completion, one cycle

Behaviour:
- Region decode: r = cpu_addr[ADDR_W-1 -: REGION_W].
  - r==0: internal.
  - 1≤r≤NUM_CH: channel r-1.
  - otherwise: unmapped.
- Access present = cpu_re | cpu_we. If both are asserted, the access is treated as a write.
- Internal accesses never stall:
  - dm_we = cpu_we & internal, combinational.
  - cpu_rdata = dm_rdata, combinational.
- Unmapped accesses never stall:
  - bus_err=1 in that cycle.
  - cpu_rdata=ERR_DATA.
  - dm_we=0; no ch_req.
- FSM states IDLE, WAIT, DONE.
  - IDLE:
    - On an external mapped access, stall=1 combinationally.
    - Latch addr, wdata, we and channel index.
    - Clear the timeout counter.
    - Next state WAIT.
  - WAIT:
    - ch_req[idx]=1 and stall=1.
    - ch_addr, ch_wdata and ch_we driven from the latches.
    - Counter increments each cycle.
    - On ch_ack[idx]: capture ch_rdata slice; next state DONE.
    - Else if TIMEOUT≠0 and counter==TIMEOUT-1: capture ERR_DATA, set the err flag; next state DONE.
    - Ack beats timeout when both occur in the same cycle.
  - DONE:
    - stall=0; cpu_rdata = captured data.
    - bus_err = err flag.
    - The pipeline advances at this edge; the access still visible this cycle must not restart.
    - Next state IDLE unconditionally.
- Latency: with ack in the first WAIT cycle, stall is high for 2 cycles (IDLE, WAIT) and data is valid in DONE. Each extra wait cycle adds 1.
- Acks ignored: ch_ack on a non-selected channel, and any ack in IDLE/DONE.
- ch_req, ch_we, ch_addr and ch_wdata are registered outputs; ch_addr/ch_wdata hold their values outside WAIT.
- Reset values (any time, including mid-WAIT):
  - state=IDLE, ch_req=0, ch_we=0, ch_addr=0, ch_wdata=0, counter=0, err flag=0, captured data=0.
  - stall and bus_err follow the combinational rules with state=IDLE.

Decomposition:
- Package mmio_pkg:
  - state enum {IDLE, WAIT, DONE}
  - REGION_INT=0
  - ERR_DATA default
  - region-to-channel helper function
- Sub-module mmio_decode (combinational): cpu_addr → {is_int, is_unmapped, ch_idx}. Reused by the future I/O address map.

Test Plan:
- Internal load/store: cpu_addr=16'h0040, cpu_re=1, dm_rdata=16'h1234 → cpu_rdata=16'h1234 same cycle; stall=0; ch_req=0. Store to the same address → dm_we=1.
- Ch0 read, zero wait: addr=16'h2010, re=1, ack in first WAIT cycle with ch_rdata[15:0]=16'hBEEF → ch_req=4'b0001 for 1 cycle; stall high for 2 cycles; DONE: cpu_rdata=16'hBEEF, stall=0.
- Ch2 write, 5 wait cycles: addr=16'h6004, wdata=16'hA5A5 → ch_we=1, ch_addr=16'h6004, ch_wdata=16'hA5A5 held; stall high for 7 cycles; bus_err=0.
- Timeout: ch1 read, never acked, TIMEOUT=15 → ch_req high exactly 15 cycles; DONE: cpu_rdata=16'hDEAD, bus_err=1 for 1 cycle.
- Unmapped: addr=16'hA000 (r=5, NUM_CH=4), re=1 → bus_err=1, cpu_rdata=16'hDEAD, stall=0, no req.
- Reset mid-WAIT plus stray acks:
  - Ch3 access; pulse ch_ack[0] → no completion.
  - Assert rst_n=0 in WAIT → ch_req=0 and stall=0 immediately.
  - After release, a new ch0 access completes normally.
